// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin REQ#/GNT# arbitration with bus
// parking, grant timeout and early grant removal.
// Ports: PCI_CLK, RESET (async, active high), REQ_n[N_SLOTS] (active low),
// FRAME_n, IRDY_n (resolved bus), GNT_n[N_SLOTS] (registered, active low),
// OWNER (current/last grant index), OWNER_VALID (a GNT_n is low),
// PARKED (current grant is a park grant).
module pci_arbiter #(
  parameter int N_SLOTS     = 4,
  parameter bit PARK_EN     = 1'b1,
  parameter int PARK_SLOT   = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                       PCI_CLK,
  input  logic                       RESET,
  input  logic [N_SLOTS-1:0]         REQ_n,
  input  logic                       FRAME_n,
  input  logic                       IRDY_n,
  output logic [N_SLOTS-1:0]         GNT_n,
  output logic [$clog2(N_SLOTS)-1:0] OWNER,
  output logic                       OWNER_VALID,
  output logic                       PARKED
);

  localparam int OW = $clog2(N_SLOTS);
  typedef logic [OW-1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY
  } state_t;

  state_t state_q, state_d;
  idx_t owner_q, owner_d;
  idx_t last_q, last_d;
  logic [7:0] timer_q, timer_d;
  // hold: grant still driven to the owner (cleared by early removal)
  logic hold_q, hold_d;
  logic parked_q, parked_d;
  logic valid_q, valid_d;
  logic [N_SLOTS-1:0] gnt_n_q, gnt_n_d;

  logic bus_idle;
  logic any_req;
  logic other_req;
  idx_t pick;
  idx_t cand_idx;
  int cand;
  logic [N_SLOTS-1:0] own_oh;

  assign bus_idle = FRAME_n & IRDY_n;
  assign own_oh = {{(N_SLOTS-1){1'b0}}, 1'b1} << owner_q;
  assign other_req = |(~REQ_n & ~own_oh);

  // Round-robin search starting just after the last served slot
  always_comb begin
    pick = last_q;
    any_req = 1'b0;
    cand = 0;
    cand_idx = '0;
    for (int i = 1; i <= N_SLOTS; i++) begin
      cand = (int'(last_q) + i) % N_SLOTS;
      cand_idx = idx_t'(cand);
      if (!any_req && !REQ_n[cand_idx]) begin
        any_req = 1'b1;
        pick = cand_idx;
      end
    end
  end

  always_ff @(posedge PCI_CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      last_q   <= idx_t'(N_SLOTS - 1);
      timer_q  <= '0;
      hold_q   <= 1'b0;
      parked_q <= 1'b0;
      valid_q  <= 1'b0;
      gnt_n_q  <= '1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      hold_q   <= hold_d;
      parked_q <= parked_d;
      valid_q  <= valid_d;
      gnt_n_q  <= gnt_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    timer_d  = timer_q;
    hold_d   = hold_q;
    parked_d = parked_q;
    unique case (state_q)
      S_IDLE: begin
        hold_d   = 1'b0;
        parked_d = 1'b0;
        timer_d  = '0;
        if (any_req) begin
          state_d = S_GRANT;
          owner_d = pick;
          hold_d  = 1'b1;
        end else if (PARK_EN) begin
          state_d  = S_GRANT;
          owner_d  = idx_t'(PARK_SLOT);
          parked_d = 1'b1;
          hold_d   = 1'b1;
        end
      end
      S_GRANT: begin
        if (!FRAME_n) begin
          state_d  = S_BUSY;
          last_d   = owner_q;
          timer_d  = '0;
          parked_d = 1'b0;
        end else if (parked_q) begin
          if (any_req) begin
            state_d  = S_IDLE;
            hold_d   = 1'b0;
            parked_d = 1'b0;
          end
        end else if (REQ_n[owner_q] && bus_idle) begin
          state_d = S_IDLE;
          hold_d  = 1'b0;
        end else if (bus_idle
                     && timer_q == 8'(GNT_TIMEOUT - 1)) begin
          // master never started: it forfeits its turn
          state_d = S_IDLE;
          last_d  = owner_q;
          hold_d  = 1'b0;
        end else if (bus_idle) begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_BUSY: begin
        if (bus_idle) begin
          if (hold_q && !REQ_n[owner_q]) begin
            state_d = S_GRANT;
            timer_d = '0;
          end else begin
            state_d = S_IDLE;
            hold_d  = 1'b0;
          end
        end else if (other_req) begin
          hold_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
      end
    endcase
  end

  // Outputs are computed from next state and registered with it
  always_comb begin
    gnt_n_d = '1;
    valid_d = (state_d != S_IDLE) && hold_d;
    if (valid_d) gnt_n_d[owner_d] = 1'b0;
  end

  assign GNT_n       = gnt_n_q;
  assign OWNER       = owner_q;
  assign OWNER_VALID = valid_q;
  assign PARKED      = parked_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Testbench for pci_arbiter: scripted bus cycles with expected
// outputs queued per edge and compared after the edge.
module tb_pci_arbiter;

  logic       PCI_CLK;
  logic       RESET;
  logic [3:0] REQ_n;
  logic       FRAME_n;
  logic       IRDY_n;
  logic [3:0] GNT_n;
  logic [1:0] OWNER;
  logic       OWNER_VALID;
  logic       PARKED;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] own;
    logic       v;
    logic       p;
  } exp_t;

  exp_t exp_q[$];

  pci_arbiter #(
    .N_SLOTS(4),
    .PARK_EN(1'b1),
    .PARK_SLOT(2),
    .GNT_TIMEOUT(16)
  ) dut (
    .PCI_CLK(PCI_CLK),
    .RESET(RESET),
    .REQ_n(REQ_n),
    .FRAME_n(FRAME_n),
    .IRDY_n(IRDY_n),
    .GNT_n(GNT_n),
    .OWNER(OWNER),
    .OWNER_VALID(OWNER_VALID),
    .PARKED(PARKED)
  );

  initial PCI_CLK = 1'b0;
  always #5 PCI_CLK = ~PCI_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gv(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << s);
  endfunction

  task automatic rst();
    RESET = 1'b1;
    REQ_n = 4'hF;
    FRAME_n = 1'b1;
    IRDY_n = 1'b1;
    #1;
    chk("rst_gnt", 32'(GNT_n), 32'hF);
    chk("rst_valid", 32'(OWNER_VALID), 32'd0);
    chk("rst_owner", 32'(OWNER), 32'd0);
    chk("rst_parked", 32'(PARKED), 32'd0);
    @(posedge PCI_CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic step(input logic [3:0] req, input logic f,
                      input logic i, input logic [3:0] eg,
                      input logic [1:0] eo, input logic ev,
                      input logic ep);
    exp_t e;
    REQ_n = req;
    FRAME_n = f;
    IRDY_n = i;
    exp_q.push_back('{gnt: eg, own: eo, v: ev, p: ep});
    @(posedge PCI_CLK);
    #1;
    e = exp_q.pop_front();
    chk("gnt", 32'(GNT_n), 32'(e.gnt));
    chk("owner", 32'(OWNER), 32'(e.own));
    chk("valid", 32'(OWNER_VALID), 32'(e.v));
    chk("parked", 32'(PARKED), 32'(e.p));
  endtask

  initial begin
    RESET = 1'b0;
    REQ_n = 4'hF;
    FRAME_n = 1'b1;
    IRDY_n = 1'b1;
    #1;

    // park on slot 2, never times out, then slot 0 request
    rst();
    step(4'hF, 1, 1, 4'b1011, 2, 1, 1);
    repeat (20) step(4'hF, 1, 1, 4'b1011, 2, 1, 1);
    step(4'b1110, 1, 1, 4'b1111, 2, 0, 0);
    step(4'b1110, 1, 1, 4'b1110, 0, 1, 0);

    // round robin 0,1,2,3,0 with 3-cycle FRAME transactions
    rst();
    for (int m = 0; m < 5; m++) begin
      step(4'h0, 1, 1, gv(m % 4), 2'(m % 4), 1, 0);
      step(4'h0, 0, 1, gv(m % 4), 2'(m % 4), 1, 0);
      step(4'h0, 0, 0, 4'hF, 2'(m % 4), 0, 0);
      step(4'h0, 0, 0, 4'hF, 2'(m % 4), 0, 0);
      step(4'h0, 1, 0, 4'hF, 2'(m % 4), 0, 0);
      step(4'h0, 1, 1, 4'hF, 2'(m % 4), 0, 0);
    end

    // timeout: slot 1 holds grant 16 cycles, then slot 2 wins
    rst();
    step(4'b1001, 1, 1, 4'b1101, 1, 1, 0);
    repeat (15) step(4'b1001, 1, 1, 4'b1101, 1, 1, 0);
    step(4'b1001, 1, 1, 4'b1111, 1, 0, 0);
    step(4'b1001, 1, 1, 4'b1011, 2, 1, 0);

    // early removal: slot 3 requests while slot 0 busy
    rst();
    step(4'b1110, 1, 1, 4'b1110, 0, 1, 0);
    step(4'b1110, 0, 1, 4'b1110, 0, 1, 0);
    step(4'b0110, 0, 0, 4'b1111, 0, 0, 0);
    step(4'b0110, 0, 0, 4'b1111, 0, 0, 0);
    step(4'b0110, 1, 1, 4'b1111, 0, 0, 0);
    step(4'b0110, 1, 1, 4'b0111, 3, 1, 0);

    // back-to-back on slot 2, then withdraw and park
    rst();
    step(4'b1011, 1, 1, 4'b1011, 2, 1, 0);
    for (int t = 0; t < 2; t++) begin
      step(4'b1011, 0, 1, 4'b1011, 2, 1, 0);
      step(4'b1011, 0, 0, 4'b1011, 2, 1, 0);
      step(4'b1011, 1, 1, 4'b1011, 2, 1, 0);
    end
    step(4'b1111, 1, 1, 4'b1111, 2, 0, 0);
    step(4'b1111, 1, 1, 4'b1011, 2, 1, 1);

    // FRAME wins over simultaneous REQ withdrawal
    rst();
    step(4'b1110, 1, 1, 4'b1110, 0, 1, 0);
    step(4'b1111, 0, 1, 4'b1110, 0, 1, 0);
    step(4'b1111, 1, 1, 4'b1111, 0, 0, 0);
    step(4'b1111, 1, 1, 4'b1011, 2, 1, 1);

    // request withdrawn while granted
    rst();
    step(4'b1101, 1, 1, 4'b1101, 1, 1, 0);
    step(4'b1111, 1, 1, 4'b1111, 1, 0, 0);

    // async reset during BUSY, then slot 0 first again
    rst();
    step(4'b1110, 1, 1, 4'b1110, 0, 1, 0);
    step(4'b1110, 0, 1, 4'b1110, 0, 1, 0);
    rst();
    step(4'b0110, 1, 1, 4'b1110, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_arbiter.md
# pci_arbiter

Central PCI bus arbiter for the simbus PCI model. It samples the REQ# lines of up to N device slots and drives their GNT# lines, using fair round-robin order with optional bus parking and a grant-timeout for masters that never start. It watches FRAME#/IRDY# to detect bus idle, so grant hand-off happens only at legal points. It sits on the bus side of the slots and owns all GNT# signals.

## Interface
- N_SLOTS, 4: number of requesters (2..16).
- PARK_EN, 1: when 1, the bus is parked on PARK_SLOT whenever no REQ# is asserted.
- PARK_SLOT, 0: slot index that receives a parked grant.
- GNT_TIMEOUT, 16: number of idle-bus cycles a granted master has to assert FRAME# before its grant is revoked (2..255).

Ports:
- PCI_CLK  in  1  bus clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_n  in  N_SLOTS  per-slot request, active low.
- FRAME_n  in  1  resolved bus FRAME#.
- IRDY_n  in  1  resolved bus IRDY#.
- GNT_n  out  N_SLOTS  per-slot grant, active low, registered; at most one bit is low.
- OWNER  out  clog2(N_SLOTS)  index of the currently or most recently granted slot.
- OWNER_VALID  out  1  high while any GNT_n bit is low.
- PARKED  out  1  high while the current grant is a park grant (no request behind it).

## Operation
- Bus idle means FRAME_n=1 and IRDY_n=1, sampled on the same edge.
- Round-robin pick: search slots last+1, last+2, … mod N_SLOTS; the first slot with REQ_n=0 wins. `last` resets to N_SLOTS-1, so slot 0 has first priority after reset.
- States:
  - IDLE: all GNT_n are high. With any request, the pick is granted and the state goes to GRANT (PARKED=0). With no request and PARK_EN=1, PARK_SLOT is granted and the state goes to GRANT (PARKED=1). Otherwise the state stays IDLE.
  - GRANT: GNT_n[OWNER]=0 and the timer counts edges where the bus is idle.
    - FRAME_n=0 sampled → BUSY, last←OWNER, timer cleared. This applies to parked grants too; PARKED clears.
    - Not parked, REQ_n[OWNER]=1, bus idle → IDLE (request withdrawn).
    - Not parked, timer reaches GNT_TIMEOUT-1 → IDLE, last←OWNER (the slot loses its turn).
    - Parked, any REQ_n=0 → IDLE. Parked grants never time out.
  - BUSY: the transaction is in progress.
    - While any other slot requests, GNT_n[OWNER] is driven high (early removal). The master finishes its current transaction.
    - When the bus is idle on a later edge: if GNT is still held and REQ_n[OWNER]=0, go to GRANT with the same OWNER and the timer cleared (back-to-back). Otherwise go to IDLE.
- An owner change always passes through IDLE, so every hand-off has ≥1 cycle with all GNT_n high. GNT_n is never low on two slots at once.
- FRAME_n/IRDY_n are evaluated only in GRANT and BUSY; IDLE ignores them.

## Timing
- Reset (asynchronous, immediate): GNT_n all 1, OWNER=0, OWNER_VALID=0, PARKED=0, state IDLE, last=N_SLOTS-1, timer=0.
- Release of reset: arbitration starts on the first rising edge with RESET=0.
- Latency: REQ_n sampled low in IDLE at edge k → GNT_n low after edge k (one-edge latency).
- Hand-off to a new owner: the old GNT rises at edge j, and the new GNT falls no earlier than edge j+1.
- Timeout: grant given at edge k with the bus continuously idle → GNT_n rises after edge k+GNT_TIMEOUT.
- Simultaneous REQ deassert and FRAME assert in GRANT: FRAME wins (→ BUSY).
- Reset mid-transaction: all grants are released immediately. The arbiter does not wait for bus idle.
- OWNER_VALID and PARKED are registered alongside GNT_n and always agree with it on the same cycle.

## Test plan
- Reset/park: PARK_EN=1, PARK_SLOT=2, no requests → after the first edge GNT_n=4'b1011, PARKED=1. Then REQ_n=4'b1110 → next edge GNT_n=4'b1111, following edge GNT_n=4'b1110, PARKED=0.
- Round robin: all four REQ_n held low, each master runs a 3-cycle FRAME transaction → grant order 0,1,2,3,0. Every hand-off shows ≥1 cycle of GNT_n=4'b1111.
- Timeout: slot 1 requests and never asserts FRAME_n, with GNT_TIMEOUT=16 → GNT_n[1] is low for exactly 16 cycles. Slot 1 then ranks last against slot 2's pending request.
- Early removal: slot 0 in BUSY, slot 3 asserts REQ_n → GNT_n[0] rises on the next edge. GNT_n[3] falls only after FRAME_n=IRDY_n=1 is sampled, plus one IDLE cycle.
- Back-to-back: only slot 2 requesting, two consecutive transactions → GNT_n[2] stays low throughout and OWNER=2 is constant.
- Async reset: assert RESET between edges during BUSY → GNT_n=all 1 and OWNER_VALID=0 without waiting for a clock edge. After release, slot 0 has first priority.
